// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial front end for an external 8-bit serial
// shift register. Words arrive over a valid/ready handshake and leave one
// bit per clock on ser_out; a one-entry holding buffer allows back-to-back
// frames with no fill gap.
//
// Handshake: a word is taken on a rising clk edge where in_valid && in_ready.
// in_ready is a flop (= !buf_full) with no combinational path from in_valid.
// While in_ready is low, in_data / in_msb_first are ignored, and the source
// keeps in_valid asserted until the word is taken.
module serial_feeder #(
    parameter int   WIDTH = 8,
    parameter logic FILL  = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             frame_done
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_word;
    logic             sh_msb;
    logic [WIDTH-1:0] buf_data;
    logic             buf_msb;
    logic             buf_full;

    logic             accept;
    logic [WIDTH-1:0] ld_word;
    logic             ld_msb;
    logic             ld_first;
    logic             nxt_bit;

    assign accept = in_valid && in_ready;

    // The word loaded into the shifter always comes from the buffer when it
    // holds one (preserves word order), otherwise straight from the input.
    // In IDLE the buffer is always empty, so this also covers the IDLE load.
    assign ld_word  = buf_full ? buf_data : in_data;
    assign ld_msb   = buf_full ? buf_msb  : in_msb_first;
    assign ld_first = ld_msb ? ld_word[WIDTH-1] : ld_word[0];

    // sh_word is shifted after each presented bit, so the next bit always
    // sits next to the end that was just presented.
    assign nxt_bit = sh_msb ? sh_word[WIDTH-2] : sh_word[1];

    // Control FSM, shifter, holding buffer and all registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sh_word    <= '0;
            sh_msb     <= 1'b0;
            buf_data   <= '0;
            buf_msb    <= 1'b0;
            buf_full   <= 1'b0;
            in_ready   <= 1'b1;
            ser_out    <= FILL;
            ser_active <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sh_word    <= ld_word;
                        sh_msb     <= ld_msb;
                        ser_out    <= ld_first;
                        ser_active <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != LAST) begin
                        cnt     <= cnt + CW'(1);
                        sh_word <= sh_msb ? (sh_word << 1) : (sh_word >> 1);
                        ser_out <= nxt_bit;
                        // Mid-frame accept can only happen with the buffer
                        // empty (in_ready high), so it parks in the buffer.
                        if (accept) begin
                            buf_data <= in_data;
                            buf_msb  <= in_msb_first;
                            buf_full <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end else begin
                        // Last bit was sampled downstream on this edge.
                        frame_done <= 1'b1;
                        if (buf_full || accept) begin
                            sh_word  <= ld_word;
                            sh_msb   <= ld_msb;
                            ser_out  <= ld_first;
                            cnt      <= '0;
                            buf_full <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            ser_out    <= FILL;
                            ser_active <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: directed bench for serial_feeder with behavioural
// shiftRight / shiftLeft downstream registers fed from ser_out.
module tb_serial_feeder;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in_data;
    logic       in_msb_first;
    logic       in_valid;
    logic       in_ready;
    logic       ser_out;
    logic       ser_active;
    logic       frame_done;

    logic [7:0] so_right = 8'h00;
    logic [7:0] so_left  = 8'h00;

    int checks = 0;
    int errors = 0;

    serial_feeder #(.WIDTH(8), .FILL(1'b0)) dut (
        .clk          (clk),
        .clr          (clr),
        .in_data      (in_data),
        .in_msb_first (in_msb_first),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ser_out      (ser_out),
        .ser_active   (ser_active),
        .frame_done   (frame_done)
    );

    // clock / downstream registers
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        so_right <= {ser_out, so_right[7:1]};
        so_left  <= {so_left[6:0], ser_out};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word from idle; seq lists the bits in transmit order, first bit leftmost.
    task automatic send_one(input logic [7:0] d, input logic msb, input logic [7:0] seq);
        in_data      = d;
        in_msb_first = msb;
        in_valid     = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check("ser_bit", ser_out, seq[7-k]);
            check("ser_active", ser_active, 1'b1);
            check("fd_early", frame_done, 1'b0);
            tick();
        end
        check("frame_done", frame_done, 1'b1);
        check("so_word", msb ? so_left : so_right, d);
        check("active_off", ser_active, 1'b0);
        check("fill", ser_out, 1'b0);
        check("ready_idle", in_ready, 1'b1);
        tick();
        check("fd_one_cycle", frame_done, 1'b0);
    endtask

    // Three LSB-first words with in_valid held high. While the buffer is full
    // the source shows hold_a, then w2 from cycle 5 on; w2 is what the
    // edge after in_ready rises takes.
    task automatic three_words(input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] hold_a, input logic [7:0] w2);
        logic [7:0] wl [3];
        logic [7:0] cur;
        logic       exp_act, exp_fd, exp_rdy;
        wl[0] = w0;
        wl[1] = w1;
        wl[2] = w2;
        in_msb_first = 1'b0;
        in_data      = w0;
        in_valid     = 1'b1;
        tick();
        for (int c = 0; c < 26; c++) begin
            exp_act = (c <= 23);
            exp_fd  = (c == 8) || (c == 16) || (c == 24);
            exp_rdy = !(((c >= 1) && (c <= 7)) || ((c >= 9) && (c <= 15)));
            check("stream_active", ser_active, exp_act);
            check("stream_fd", frame_done, exp_fd);
            check("stream_ready", in_ready, exp_rdy);
            if (c <= 23) begin
                cur = wl[c/8];
                check("stream_bit", ser_out, cur[c%8]);
            end
            if (exp_fd) check("stream_so", so_right, wl[c/8-1]);
            case (c)
                0: in_data = w1;
                1: in_data = hold_a;
                4: in_data = w2;
                9: in_valid = 1'b0;
                default: ;
            endcase
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr          = 1'b1;
        in_data      = 8'h00;
        in_msb_first = 1'b0;
        in_valid     = 1'b0;

        // reset values while clr is held, before any clock edge
        #2;
        check("rst_ser_out", ser_out, 1'b0);
        check("rst_active", ser_active, 1'b0);
        check("rst_fd", frame_done, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        tick();
        #3;
        clr = 1'b0;

        // first edge after release accepts
        send_one(8'hA5, 1'b0, 8'b10100101);
        send_one(8'h3C, 1'b1, 8'b00111100);

        // asynchronous clear pulse mid-cycle while a word is shifting
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_clr_active", ser_active, 1'b1);
        check("pre_clr_bit", ser_out, 1'b1);
        #3;
        clr = 1'b1;
        #1;
        check("async_ser_out", ser_out, 1'b0);
        check("async_active", ser_active, 1'b0);
        check("async_fd", frame_done, 1'b0);
        check("async_ready", in_ready, 1'b1);
        #2;
        clr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("post_clr_fd", frame_done, 1'b0);
            check("post_clr_active", ser_active, 1'b0);
        end

        // back-to-back with no gap
        three_words(8'h01, 8'h80, 8'hFF, 8'hFF);

        // backpressure: 8'h11 shown while blocked, 8'h22 present on accept edge
        three_words(8'h33, 8'h44, 8'h11, 8'h22);

        // clear mid-frame with a buffered word
        in_msb_first = 1'b0;
        in_data      = 8'hF0;
        in_valid     = 1'b1;
        tick();
        in_data = 8'h0F;
        tick();
        in_valid = 1'b0;
        check("mid_buf_full", in_ready, 1'b0);
        tick();
        tick();
        check("mid_active", ser_active, 1'b1);
        #3;
        clr = 1'b1;
        #1;
        check("mid_ser_out", ser_out, 1'b0);
        check("mid_active_clr", ser_active, 1'b0);
        check("mid_fd", frame_done, 1'b0);
        check("mid_ready", in_ready, 1'b1);
        tick();
        tick();
        #3;
        clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mid_no_fd", frame_done, 1'b0);
            check("mid_idle", ser_active, 1'b0);
        end
        send_one(8'h5A, 1'b0, 8'b01011010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_feeder.md
# serial_feeder

Parallel-to-serial front end for the 8-bit serial shift registers (`shiftRight` / `shiftLeft`). It accepts bytes over a valid/ready handshake and presents them one bit per clock on `ser_out`, which drives the shift register `data` input. A one-entry holding buffer allows gapless back-to-back frames. `frame_done` marks the cycle in which the downstream register's parallel output holds the complete word.

## Interface
- `WIDTH`, 8: word width; the bit counter is clog2(WIDTH) bits.
- `FILL`, 1'b0: value driven on `ser_out` when no data bit is being presented.

Ports (reset clr, asynchronous, active-high; clock clk):
- `clk`  in  1  clock; all state updates on the rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `in_data`  in  WIDTH  word to serialise
- `in_msb_first`  in  1  bit order for this word; sampled with `in_data`
- `in_valid`  in  1  `in_data` / `in_msb_first` valid
- `in_ready`  out  1  feeder can accept a word this cycle
- `ser_out`  out  1  serial bit to the downstream shift register `data` input
- `ser_active`  out  1  `ser_out` carries a data bit this cycle
- `frame_done`  out  1  one-cycle pulse: downstream register now holds the full word

## Operation
- Accept occurs on a rising edge where `in_valid && in_ready`.
- States:
  - IDLE: nothing being shifted; the buffer is always empty.
  - SHIFT: a word is loaded in the shift register and `cnt` indexes the bit currently on `ser_out` (0..WIDTH-1).
- Routing of an accepted word:
  - Goes straight to the shift register if the state is IDLE, or if the state is SHIFT, `cnt == WIDTH-1` and the buffer is empty.
  - Otherwise goes into the holding buffer.
- Word order is preserved.
- Bit order:
  - `in_msb_first = 0`: bit 0 first. Use this with `shiftRight`.
  - `in_msb_first = 1`: bit WIDTH-1 first. Use this with `shiftLeft`.
  - In both cases the downstream `so` equals the word at `frame_done`.
  - The order flag is stored per word, including the buffered word.
- IDLE plus accept: `ser_out <= first bit`, `ser_active <= 1`, `cnt <= 0`, go to SHIFT.
- SHIFT with `cnt < WIDTH-1`: `cnt <= cnt + 1`, `ser_out <= next bit`.
- SHIFT with `cnt == WIDTH-1`:
  - `frame_done <= 1`.
  - If the buffer is full: load the buffered word, `ser_out <= its first bit`, `cnt <= 0`, stay in SHIFT, buffer becomes empty.
  - Else if an accept occurs on the same edge: load the accepted word the same way (bypass).
  - Else: `ser_out <= FILL`, `ser_active <= 0`, go to IDLE.
- `frame_done` is 0 on every other edge.
- `in_ready = !buf_full`, driven from a flop. There is no combinational path from `in_valid` to `in_ready`.
- Buffer full with `in_valid` high: no accept; changes on `in_data` are ignored.
- `clr` asserted at any time:
  - Immediately sets `ser_out = FILL`, `ser_active = 0`, `frame_done = 0`, `in_ready = 1`, `cnt = 0`, state IDLE, buffer empty.
  - An in-flight or buffered word is discarded, and no `frame_done` is issued for it.

## Timing
- Reset values: `ser_out = FILL`, `ser_active = 0`, `frame_done = 0`, `in_ready = 1`.
- With accept edge E0, bit k is on `ser_out` during the cycle after edge Ek (k = 0..WIDTH-1). The downstream register samples it at E(k+1).
- `frame_done` is high during the cycle after E(WIDTH), i.e. E8 for WIDTH = 8. This is the same cycle the downstream register holds the word.
- Latency from accept to first bit is one edge. Latency from accept to `frame_done` is WIDTH edges.
- Sustained throughput is one word per WIDTH cycles with no FILL gap, provided the next word is buffered or accepted by edge E(WIDTH).
- `in_ready` drops on the edge the buffer fills and rises on the edge the buffered word is loaded.
- `clr` release: the first accept may occur on the first rising edge with `clr` low.

## Test plan
- Reset: pulse `clr` mid-cycle → `ser_out = 0`, `ser_active = 0`, `frame_done = 0`, `in_ready = 1`, asynchronously, without waiting for a clock edge.
- Single LSB-first word: 8'hA5 with `in_msb_first = 0`, `shiftRight` downstream.
  - `ser_out` = 1,0,1,0,0,1,0,1 on cycles 1-8.
  - `frame_done` high cycle 9 only, with `so == 8'hA5`.
  - `ser_active` low from cycle 9.
- Single MSB-first word: 8'h3C with `in_msb_first = 1`, `shiftLeft` downstream.
  - `ser_out` = 0,0,1,1,1,1,0,0.
  - At `frame_done`, `so == 8'h3C`.
- Back-to-back: 8'h01, 8'h80, 8'hFF with `in_valid` held high.
  - `ser_active` high for 24 consecutive cycles with no FILL gap.
  - `frame_done` at cycles 9, 17 and 25.
  - `in_ready` low whenever the buffer is full.
- Backpressure: buffer full, `in_valid = 1`, `in_data` toggles 8'h11 → 8'h22.
  - Neither value is accepted until `in_ready` rises.
  - The value present on the accept edge is the one sent.
- Reset mid-frame: 8'hF0 shifting after 3 bits, 8'h0F buffered, assert `clr`.
  - All outputs go to reset values; no `frame_done`.
  - After release, 8'h5A is sent cleanly with `frame_done` at E8.
